// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS core: FSM states, opcode/funct
// encodings and the ALU operation selector.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic funct_legal(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                               funct_legal = 1'b0;
        endcase
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  funct_to_alu = ALU_ADD;
            FN_SUB:  funct_to_alu = ALU_SUB;
            FN_AND:  funct_to_alu = ALU_AND;
            FN_OR:   funct_to_alu = ALU_OR;
            FN_SLT:  funct_to_alu = ALU_SLT;
            default: funct_to_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous
// write port; register 0 is hard-wired to zero.
module mc_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [32];

    // Register array with reset clear; writes to register 0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mc_core.sv
// Multicycle MIPS subset core (lw, sw, add/sub/and/or/slt, beq, addi, j)
// sharing a single memory port between instruction fetch and data access.
module mc_core
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            trap
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    logic [XLEN-1:0] rf_rd1_s, rf_rd2_s, rf_wd_s;
    logic [4:0]      rf_wa_s;
    logic            rf_we_s;

    logic [XLEN-1:0] alu_a_s, alu_b_s, alu_y_s;
    alu_op_e         alu_op_s;

    logic            mem_req_s, mem_we_s, retire_s;
    logic [XLEN-1:0] mem_addr_s;

    logic [5:0]      opcode_s, funct_s;
    logic [4:0]      rs_s, rt_s, rd_s;
    logic [XLEN-1:0] sext_imm_s;

    assign opcode_s   = ir_q[31:26];
    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign funct_s    = ir_q[5:0];
    assign sext_imm_s = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    mc_regfile #(.XLEN(XLEN)) u_regfile (
        .clk   (clk),
        .rst_n (reset),
        .ra1_i (rs_s),
        .ra2_i (rt_s),
        .rd1_o (rf_rd1_s),
        .rd2_o (rf_rd2_s),
        .we_i  (rf_we_s),
        .wa_i  (rf_wa_s),
        .wd_i  (rf_wd_s)
    );

    // ALU operand selection: the single adder also serves pc+4 and branch target
    always_comb begin
        alu_a_s  = a_q;
        alu_b_s  = b_q;
        alu_op_s = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_a_s = pc_q;
                alu_b_s = {{(XLEN-3){1'b0}}, 3'd4};
            end
            S_DECODE: begin
                alu_a_s = pc_q;
                alu_b_s = {sext_imm_s[XLEN-3:0], 2'b00};
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_b_s = sext_imm_s;
            end
            S_EXEC: begin
                alu_op_s = funct_to_alu(funct_s);
            end
            default: begin
                alu_op_s = ALU_ADD;
            end
        endcase
    end

    // ALU datapath; adds and subtracts wrap, slt is a signed compare
    always_comb begin
        alu_y_s = '0;
        case (alu_op_s)
            ALU_ADD: alu_y_s = alu_a_s + alu_b_s;
            ALU_SUB: alu_y_s = alu_a_s - alu_b_s;
            ALU_AND: alu_y_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_y_s = alu_a_s | alu_b_s;
            ALU_SLT: alu_y_s = {{(XLEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
            default: alu_y_s = '0;
        endcase
    end

    // Next-state, datapath register updates and memory/retire outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        mdr_d      = mdr_q;
        rf_we_s    = 1'b0;
        rf_wa_s    = rt_s;
        rf_wd_s    = alu_out_q;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = pc_q;
        retire_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = alu_y_s;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d       = rf_rd1_s;
                b_d       = rf_rd2_s;
                alu_out_d = alu_y_s;
                case (opcode_s)
                    OP_RTYPE:     state_d = funct_legal(funct_s) ? S_EXEC : S_TRAP;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_out_d = alu_y_s;
                state_d   = (opcode_s == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_s  = 1'b1;
                mem_addr_s = alu_out_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                rf_we_s  = 1'b1;
                rf_wd_s  = mdr_q;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s  = 1'b1;
                mem_we_s   = 1'b1;
                mem_addr_s = alu_out_q;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_out_d = alu_y_s;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_s  = 1'b1;
                rf_wa_s  = rd_s;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) begin
                    pc_d = alu_out_q;
                end else begin
                    pc_d = pc_q;
                end
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_out_d = alu_y_s;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_d     = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0000;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Gating with reset drops an outstanding request the moment reset asserts
    assign mem_req   = mem_req_s & reset;
    assign mem_we    = mem_we_s & reset;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign retire    = retire_s;
    assign trap      = (state_q == S_TRAP);

endmodule
